// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM states
//   RETRY_W         : width of the consecutive-timeout counter
//   LOSS_CNT_W      : width of the saturating lock-loss counter
//   max3()          : helper used to size the shared cycle counter
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PULSE,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_sup_state_t;

  localparam int unsigned RETRY_W    = 4;
  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL/system status bundle.
//   locked          : PLL locked flag (asynchronous to clk)
//   pll_rst         : PLL reset, active-high
//   sys_rst         : downstream system reset, active-high
//   pll_ok          : high while the clock is qualified
//   fault           : high once retries are exhausted
//   retry_count     : consecutive lock timeouts since last RUN entry
//   lock_loss_count : saturating count of lock losses while running
// master = supervisor side, slave = PLL wrapper / consumer side.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic                  locked;
  logic                  pll_rst;
  logic                  sys_rst;
  logic                  pll_ok;
  logic                  fault;
  logic [RETRY_W-1:0]    retry_count;
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    input  locked,
    output pll_rst, sys_rst, pll_ok, fault, retry_count, lock_loss_count
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, pll_ok, fault, retry_count, lock_loss_count
  );

endinterface

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous reset to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input bit
//   q   : synchronised output (STAGES cycles of latency)
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock over a stability
// window, releases the system reset only while lock holds, retries on lock
// timeout and latches FAULT after MAX_RETRIES consecutive timeouts.
//   clk : reference clock (PLL refclk)
//   rst : asynchronous active-high reset
//   sup : status bundle (master side), see pll_lock_supervisor_if
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input logic                   clk,
  input logic                   rst,
  pll_lock_supervisor_if.master sup
);

  localparam int unsigned CNT_MAX =
    max3(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  pll_sup_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  pll_ok_q, pll_ok_d;
  logic                  fault_q, fault_d;
  logic                  locked_s;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_locked_sync (
    .clk (clk),
    .rst (rst),
    .d   (sup.locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      PULSE: begin
        if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : PULSE;
        end
      end
      STABLE: begin
        // A drop on the final window cycle still wins.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PULSE;
          if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = PULSE;
    endcase

    // Counter only runs in timed states, so it never wraps in RUN/FAULT.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == PULSE || state_q == WAIT_LOCK || state_q == STABLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are registered from the next state so they switch on the same
    // edge as the state register.
    pll_rst_d = (state_d == PULSE) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    pll_ok_d  = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PULSE;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      pll_ok_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      pll_ok_q  <= pll_ok_d;
      fault_q   <= fault_d;
    end
  end

  assign sup.pll_rst         = pll_rst_q;
  assign sup.sys_rst         = sys_rst_q;
  assign sup.pll_ok          = pll_ok_q;
  assign sup.fault           = fault_q;
  assign sup.retry_count     = retry_q;
  assign sup.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with small timing parameters.
// Output vector layout: {pll_rst, sys_rst, pll_ok, fault, retry[3:0], loss[7:0]}.
module tb_pll_lock_supervisor;

  logic clk;
  logic rst;

  pll_lock_supervisor_if sup_if ();

  pll_lock_supervisor #(
    .RESET_PULSE_CYCLES  (4),
    .LOCK_TIMEOUT_CYCLES (100),
    .LOCK_STABLE_CYCLES  (20),
    .SYNC_STAGES         (2),
    .MAX_RETRIES         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sup (sup_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] outs;
  } sb_t;

  typedef struct {
    logic        lk;
    int unsigned cycles;
    string       name;
    logic [15:0] outs;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [15:0] mk(input logic p, input logic s, input logic o,
                                     input logic f, input logic [3:0] r,
                                     input logic [7:0] l);
    return {p, s, o, f, r, l};
  endfunction

  function automatic logic [15:0] pul(input logic [3:0] r, input logic [7:0] l);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, r, l);
  endfunction

  function automatic logic [15:0] wt(input logic [3:0] r, input logic [7:0] l);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, r, l);
  endfunction

  function automatic logic [15:0] rn(input logic [7:0] l);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, l);
  endfunction

  function automatic logic [15:0] flt(input logic [3:0] r);
    return mk(1'b1, 1'b1, 1'b0, 1'b1, r, 8'd0);
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_pop();
    sb_t         s;
    logic [15:0] act;
    act = {sup_if.pll_rst, sup_if.sys_rst, sup_if.pll_ok, sup_if.fault,
           sup_if.retry_count, sup_if.lock_loss_count};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      return;
    end
    s = sb_q.pop_front();
    if (act !== s.outs) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b pll_ok=%b fault=%b retry=%0d loss=%0d, want pll_rst=%b sys_rst=%b pll_ok=%b fault=%b retry=%0d loss=%0d",
               s.name, act[15], act[14], act[13], act[12], act[11:8], act[7:0],
               s.outs[15], s.outs[14], s.outs[13], s.outs[12], s.outs[11:8], s.outs[7:0]);
    end
  endtask

  // Drive locked, record the expectation, advance n cycles, then compare.
  task automatic drive(input logic lk, input int unsigned n, input string nm,
                       input logic [15:0] e);
    sb_t s;
    sup_if.locked = lk;
    s.name = nm;
    s.outs = e;
    sb_q.push_back(s);
    step(n);
    check_pop();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sup_if.locked = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Assert rst between clock edges and check outputs before the next edge.
  task automatic async_rst(input string nm);
    sb_t s;
    s.name = nm;
    s.outs = pul(4'd0, 8'd0);
    sb_q.push_back(s);
    rst = 1'b1;
    #2;
    check_pop();
  endtask

  initial begin
    rst = 1'b1;
    sup_if.locked = 1'b0;

    // Locked tied low: pulse, timeouts, retries, fault.
    tbl[0]  = '{1'b0, 0,   "reset_state",  pul(4'd0, 8'd0)};
    tbl[1]  = '{1'b0, 3,   "pulse_hold",   pul(4'd0, 8'd0)};
    tbl[2]  = '{1'b0, 1,   "pulse_end",    wt(4'd0, 8'd0)};
    tbl[3]  = '{1'b0, 99,  "wait_pre_to1", wt(4'd0, 8'd0)};
    tbl[4]  = '{1'b0, 1,   "timeout1",     pul(4'd1, 8'd0)};
    tbl[5]  = '{1'b0, 3,   "pulse2_hold",  pul(4'd1, 8'd0)};
    tbl[6]  = '{1'b0, 1,   "pulse2_end",   wt(4'd1, 8'd0)};
    tbl[7]  = '{1'b0, 100, "timeout2",     pul(4'd2, 8'd0)};
    tbl[8]  = '{1'b0, 4,   "pulse3_end",   wt(4'd2, 8'd0)};
    tbl[9]  = '{1'b0, 99,  "wait_pre_to3", wt(4'd2, 8'd0)};
    tbl[10] = '{1'b0, 1,   "fault_entry",  flt(4'd3)};
    tbl[11] = '{1'b1, 200, "fault_hold",   flt(4'd3)};

    do_reset();
    for (int i = 0; i < 12; i++) drive(tbl[i].lk, tbl[i].cycles, tbl[i].name, tbl[i].outs);
    async_rst("rst_from_fault");

    // Clean lock: rise 10 cycles after pll_rst falls; release 23 cycles later.
    do_reset();
    drive(1'b0, 4,  "c_wait",     wt(4'd0, 8'd0));
    drive(1'b0, 10, "c_pre_lock", wt(4'd0, 8'd0));
    drive(1'b1, 22, "c_stable",   wt(4'd0, 8'd0));
    drive(1'b1, 1,  "c_run",      rn(8'd0));

    // Loss of lock in RUN, 4-cycle pulse, re-lock.
    drive(1'b0, 2,  "l_still_run", rn(8'd0));
    drive(1'b0, 1,  "l_pulse",     pul(4'd0, 8'd1));
    drive(1'b0, 3,  "l_pulse_hold", pul(4'd0, 8'd1));
    drive(1'b0, 1,  "l_wait",      wt(4'd0, 8'd1));
    drive(1'b1, 22, "l_relock",    wt(4'd0, 8'd1));
    drive(1'b1, 1,  "l_run",       rn(8'd1));
    async_rst("rst_mid_run");

    // Glitchy lock: high 8, low 5, then high.
    do_reset();
    drive(1'b0, 4,  "g_wait",   wt(4'd0, 8'd0));
    drive(1'b1, 8,  "g_high",   wt(4'd0, 8'd0));
    drive(1'b0, 5,  "g_low",    wt(4'd0, 8'd0));
    drive(1'b1, 22, "g_relock", wt(4'd0, 8'd0));
    drive(1'b1, 1,  "g_run",    rn(8'd0));

    // locked_s falls on the final STABLE cycle: back to WAIT_LOCK.
    do_reset();
    drive(1'b0, 4,  "p_wait",       wt(4'd0, 8'd0));
    drive(1'b1, 20, "p_stable",     wt(4'd0, 8'd0));
    drive(1'b0, 3,  "p_fall_final", wt(4'd0, 8'd0));
    drive(1'b1, 22, "p_relock",     wt(4'd0, 8'd0));
    drive(1'b1, 1,  "p_run",        rn(8'd0));

    // Async reset while in STABLE.
    do_reset();
    drive(1'b0, 4,  "s_wait", wt(4'd0, 8'd0));
    drive(1'b1, 10, "s_mid",  wt(4'd0, 8'd0));
    async_rst("rst_mid_stable");

    // locked_s rises on the timeout cycle: lock wins, no retry.
    do_reset();
    drive(1'b0, 4,  "t_wait",      wt(4'd0, 8'd0));
    drive(1'b0, 97, "t_pre",       wt(4'd0, 8'd0));
    drive(1'b1, 3,  "t_lock_wins", wt(4'd0, 8'd0));
    drive(1'b1, 19, "t_stable",    wt(4'd0, 8'd0));
    drive(1'b1, 1,  "t_run",       rn(8'd0));

    // Two timeouts then lock: retry_count clears on RUN entry.
    do_reset();
    drive(1'b0, 104, "two_to1",    pul(4'd1, 8'd0));
    drive(1'b0, 104, "two_to2",    pul(4'd2, 8'd0));
    drive(1'b0, 4,   "two_wait",   wt(4'd2, 8'd0));
    drive(1'b0, 5,   "two_pre",    wt(4'd2, 8'd0));
    drive(1'b1, 22,  "two_stable", wt(4'd2, 8'd0));
    drive(1'b1, 1,   "two_run",    rn(8'd0));

    // 300 lock-loss events: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] e;
      e = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      drive(1'b0, 4,  "sat_drop", pul(4'd0, e));
      drive(1'b1, 30, "sat_run",  rn(e));
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
